// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the RV32I multi-cycle controller (master) and its shared
// datapath (slave): decode inputs, memory handshake, datapath strobes and debug counters.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             old_pc_we;
    logic [2:0]       ImmSel;
    logic [1:0]       alu_a;
    logic [1:0]       alu_b;
    logic [1:0]       alu_mode;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret;

    modport master (
        input  inst, zero, lt, ltu, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_sel, old_pc_we, ImmSel,
               alu_a, alu_b, alu_mode, reg_we, wb_sel, illegal, state,
               cycle_cnt, instret
    );

    modport slave (
        output inst, zero, lt, ltu, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_sel, old_pc_we, ImmSel,
               alu_a, alu_b, alu_mode, reg_we, wb_sel, illegal, state,
               cycle_cnt, instret
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit: one datapath step per state, memory handshake,
// sticky illegal-opcode trap, cycle and retired-instruction counters.
module mc_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_LDWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXE_R  = 4'd6,  S_EXE_I  = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR_A = 4'd11,
        S_JALR   = 4'd12, S_LUI    = 4'd13, S_AUIPC  = 4'd14, S_TRAP   = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             taken;
    logic [6:0]       opcode;
    logic [2:0]       funct3;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];

    // Reserved funct3 encodings 010/011 fall into the default and never branch.
    always_comb begin
        case (funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = !bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        illegal_d     = illegal_q;
        retire        = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_sel    = 2'b00;
        bus.old_pc_we = 1'b0;
        bus.ImmSel    = IMM_U;
        bus.alu_a     = 2'b00;
        bus.alu_b     = 2'b00;
        bus.alu_mode  = 2'b00;
        bus.reg_we    = 1'b0;
        bus.wb_sel    = 2'b00;

        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we     = 1'b1;
                    bus.old_pc_we = 1'b1;
                    bus.pc_we     = 1'b1;
                    bus.alu_b     = 2'b10;
                    state_d       = S_DECODE;
                end
            end
            // Speculatively form old_pc + imm so branch/jump/auipc targets sit in ALUOut.
            S_DECODE: begin
                bus.alu_a = 2'b10;
                bus.alu_b = 2'b01;
                case (opcode)
                    OP_BR:    bus.ImmSel = IMM_B;
                    OP_JAL:   bus.ImmSel = IMM_J;
                    OP_AUIPC: bus.ImmSel = IMM_U;
                    default:  bus.ImmSel = IMM_I;
                endcase
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXE_R;
                    OP_I:              state_d = S_EXE_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_A;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_a  = 2'b01;
                bus.alu_b  = 2'b01;
                bus.ImmSel = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d    = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = S_LDWB;
            end
            S_LDWB: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXE_R: begin
                bus.alu_a    = 2'b01;
                bus.alu_mode = 2'b01;
                state_d      = S_ALUWB;
            end
            S_EXE_I: begin
                bus.alu_a    = 2'b01;
                bus.alu_b    = 2'b01;
                bus.ImmSel   = IMM_I;
                bus.alu_mode = 2'b10;
                state_d      = S_ALUWB;
            end
            S_ALUWB, S_AUIPC: begin
                bus.reg_we = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_a    = 2'b01;
                bus.alu_mode = 2'b11;
                bus.pc_we    = taken;
                bus.pc_sel   = 2'b01;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = 2'b10;
                bus.pc_we  = 1'b1;
                bus.pc_sel = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR_A: begin
                bus.alu_a  = 2'b01;
                bus.alu_b  = 2'b01;
                bus.ImmSel = IMM_I;
                state_d    = S_JALR;
            end
            S_JALR: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = 2'b10;
                bus.pc_we  = 1'b1;
                bus.pc_sel = 2'b10;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = 2'b11;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                illegal_d = 1'b1;
                state_d   = S_TRAP;
            end
        endcase

        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        instret_d   = retire ? instret_q + CNT_ONE : instret_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= state_e'(RESET_STATE);
            illegal_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            cycle_cnt_q <= cycle_cnt_d;
            instret_q   <= instret_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.illegal   = illegal_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instret   = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm: per-cycle expected state, strobes,
// trap flag and counters, plus hand sequences for trap stickiness and async reset.
module tb_mc_ctrl_fsm;
    localparam int CNT_W = 32;

    localparam logic [3:0] ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3,  ST_LDWB   = 4'd4,  ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXE_R  = 4'd6,  ST_EXE_I  = 4'd7,  ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9,  ST_JAL    = 4'd10, ST_JALR_A = 4'd11;
    localparam logic [3:0] ST_JALR   = 4'd12, ST_LUI    = 4'd13, ST_AUIPC  = 4'd14;
    localparam logic [3:0] ST_TRAP   = 4'd15;

    // flags = {zero, lt, ltu, mem_ready}
    typedef struct {
        logic [31:0] inst;
        logic [3:0]  flags;
        logic [3:0]  st;
        logic [19:0] ctl;
        logic        ill;
        int unsigned ir;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    vec_t vecs[$];

    mc_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl_fsm #(.RESET_STATE(4'd0), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    wire [19:0] act_ctl = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we,
                           bus.pc_sel, bus.old_pc_we, bus.ImmSel, bus.alu_a, bus.alu_b,
                           bus.alu_mode, bus.reg_we, bus.wb_sel};

    function automatic logic [19:0] ctl(input logic req, we, iord, irwe, pcwe,
                                        input logic [1:0] pcsel, input logic opcwe,
                                        input logic [2:0] imm, input logic [1:0] a, b, m,
                                        input logic rwe, input logic [1:0] wb);
        return {req, we, iord, irwe, pcwe, pcsel, opcwe, imm, a, b, m, rwe, wb};
    endfunction

    function automatic vec_t mkv(input logic [31:0] inst, input logic [3:0] flags,
                                 input logic [3:0] st, input logic [19:0] c,
                                 input logic ill, input int unsigned ir);
        vec_t v;
        v.inst = inst; v.flags = flags; v.st = st; v.ctl = c; v.ill = ill; v.ir = ir;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        bus.inst = v.inst;
        {bus.zero, bus.lt, bus.ltu, bus.mem_ready} = v.flags;
        #1;
        check({tag, " state"},   64'(bus.state),     64'(v.st));
        check({tag, " ctl"},     64'(act_ctl),       64'(v.ctl));
        check({tag, " illegal"}, 64'(bus.illegal),   64'(v.ill));
        check({tag, " instret"}, 64'(bus.instret),   64'(v.ir));
        check({tag, " cycles"},  64'(bus.cycle_cnt), 64'(cyc));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [19:0] f_wait, f_go, d_i, d_u, d_b, d_j, madr_i, madr_s, mrd, mwr, ldwb;
        logic [19:0] exe_r, exe_i, aluwb, br_t, br_n, jal_c, jalra, jalr_c, lui_c, none;
        logic [31:0] i_addi, i_lw, i_sw, i_beq, i_blt, i_b010, i_add, i_lui, i_auipc;
        logic [31:0] i_jalr, i_jal, i_bad;
        int unsigned ir;

        f_wait = ctl(1,0,0,0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,0,2'b00);
        f_go   = ctl(1,0,0,1,1,2'b00,1,3'b000,2'b00,2'b10,2'b00,0,2'b00);
        d_i    = ctl(0,0,0,0,0,2'b00,0,3'b001,2'b10,2'b01,2'b00,0,2'b00);
        d_u    = ctl(0,0,0,0,0,2'b00,0,3'b000,2'b10,2'b01,2'b00,0,2'b00);
        d_b    = ctl(0,0,0,0,0,2'b00,0,3'b011,2'b10,2'b01,2'b00,0,2'b00);
        d_j    = ctl(0,0,0,0,0,2'b00,0,3'b100,2'b10,2'b01,2'b00,0,2'b00);
        madr_i = ctl(0,0,0,0,0,2'b00,0,3'b001,2'b01,2'b01,2'b00,0,2'b00);
        madr_s = ctl(0,0,0,0,0,2'b00,0,3'b010,2'b01,2'b01,2'b00,0,2'b00);
        mrd    = ctl(1,0,1,0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,0,2'b00);
        mwr    = ctl(1,1,1,0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,0,2'b00);
        ldwb   = ctl(0,0,0,0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,1,2'b01);
        exe_r  = ctl(0,0,0,0,0,2'b00,0,3'b000,2'b01,2'b00,2'b01,0,2'b00);
        exe_i  = ctl(0,0,0,0,0,2'b00,0,3'b001,2'b01,2'b01,2'b10,0,2'b00);
        aluwb  = ctl(0,0,0,0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,1,2'b00);
        br_t   = ctl(0,0,0,0,1,2'b01,0,3'b000,2'b01,2'b00,2'b11,0,2'b00);
        br_n   = ctl(0,0,0,0,0,2'b01,0,3'b000,2'b01,2'b00,2'b11,0,2'b00);
        jal_c  = ctl(0,0,0,0,1,2'b01,0,3'b000,2'b00,2'b00,2'b00,1,2'b10);
        jalra  = ctl(0,0,0,0,0,2'b00,0,3'b001,2'b01,2'b01,2'b00,0,2'b00);
        jalr_c = ctl(0,0,0,0,1,2'b10,0,3'b000,2'b00,2'b00,2'b00,1,2'b10);
        lui_c  = ctl(0,0,0,0,0,2'b00,0,3'b000,2'b00,2'b00,2'b00,1,2'b11);
        none   = '0;

        i_addi = 32'h00500093; i_lw  = 32'h0040A103; i_sw    = 32'h0020A423;
        i_beq  = 32'h00000463; i_blt = 32'h00004463; i_b010  = 32'h00002463;
        i_add  = 32'h002081B3; i_lui = 32'h123450B7; i_auipc = 32'h00001097;
        i_jalr = 32'h000080E7; i_jal = 32'h010000EF; i_bad   = 32'hFFFFFFFF;

        ir = 0;
        // addi x1,x0,5
        vecs.push_back(mkv(i_addi, 4'b0001, ST_FETCH,  f_go,  0, ir));
        vecs.push_back(mkv(i_addi, 4'b0001, ST_DECODE, d_i,   0, ir));
        vecs.push_back(mkv(i_addi, 4'b0001, ST_EXE_I,  exe_i, 0, ir));
        vecs.push_back(mkv(i_addi, 4'b0001, ST_ALUWB,  aluwb, 0, ir)); ir++;
        // lw x2,4(x1) with three wait cycles in MEMRD
        vecs.push_back(mkv(i_lw, 4'b0001, ST_FETCH,  f_go,   0, ir));
        vecs.push_back(mkv(i_lw, 4'b0001, ST_DECODE, d_i,    0, ir));
        vecs.push_back(mkv(i_lw, 4'b0000, ST_MEMADR, madr_i, 0, ir));
        vecs.push_back(mkv(i_lw, 4'b0000, ST_MEMRD,  mrd,    0, ir));
        vecs.push_back(mkv(i_lw, 4'b0000, ST_MEMRD,  mrd,    0, ir));
        vecs.push_back(mkv(i_lw, 4'b0000, ST_MEMRD,  mrd,    0, ir));
        vecs.push_back(mkv(i_lw, 4'b0001, ST_MEMRD,  mrd,    0, ir));
        vecs.push_back(mkv(i_lw, 4'b0001, ST_LDWB,   ldwb,   0, ir)); ir++;
        // sw x2,8(x1): fetch and store each wait one cycle
        vecs.push_back(mkv(i_sw, 4'b0000, ST_FETCH,  f_wait, 0, ir));
        vecs.push_back(mkv(i_sw, 4'b0001, ST_FETCH,  f_go,   0, ir));
        vecs.push_back(mkv(i_sw, 4'b0001, ST_DECODE, d_i,    0, ir));
        vecs.push_back(mkv(i_sw, 4'b0001, ST_MEMADR, madr_s, 0, ir));
        vecs.push_back(mkv(i_sw, 4'b0000, ST_MEMWR,  mwr,    0, ir));
        vecs.push_back(mkv(i_sw, 4'b0001, ST_MEMWR,  mwr,    0, ir)); ir++;
        // beq taken, beq not taken, blt taken, reserved funct3 never taken
        vecs.push_back(mkv(i_beq, 4'b0001, ST_FETCH,  f_go, 0, ir));
        vecs.push_back(mkv(i_beq, 4'b1001, ST_DECODE, d_b,  0, ir));
        vecs.push_back(mkv(i_beq, 4'b1000, ST_BRANCH, br_t, 0, ir)); ir++;
        vecs.push_back(mkv(i_beq, 4'b0001, ST_FETCH,  f_go, 0, ir));
        vecs.push_back(mkv(i_beq, 4'b0000, ST_DECODE, d_b,  0, ir));
        vecs.push_back(mkv(i_beq, 4'b0110, ST_BRANCH, br_n, 0, ir)); ir++;
        vecs.push_back(mkv(i_blt, 4'b0001, ST_FETCH,  f_go, 0, ir));
        vecs.push_back(mkv(i_blt, 4'b0100, ST_DECODE, d_b,  0, ir));
        vecs.push_back(mkv(i_blt, 4'b0100, ST_BRANCH, br_t, 0, ir)); ir++;
        vecs.push_back(mkv(i_b010, 4'b0001, ST_FETCH,  f_go, 0, ir));
        vecs.push_back(mkv(i_b010, 4'b1110, ST_DECODE, d_b,  0, ir));
        vecs.push_back(mkv(i_b010, 4'b1111, ST_BRANCH, br_n, 0, ir)); ir++;
        // add, lui, auipc, jalr
        vecs.push_back(mkv(i_add, 4'b0001, ST_FETCH,  f_go,  0, ir));
        vecs.push_back(mkv(i_add, 4'b0000, ST_DECODE, d_i,   0, ir));
        vecs.push_back(mkv(i_add, 4'b0000, ST_EXE_R,  exe_r, 0, ir));
        vecs.push_back(mkv(i_add, 4'b0000, ST_ALUWB,  aluwb, 0, ir)); ir++;
        vecs.push_back(mkv(i_lui, 4'b0001, ST_FETCH,  f_go,  0, ir));
        vecs.push_back(mkv(i_lui, 4'b0000, ST_DECODE, d_i,   0, ir));
        vecs.push_back(mkv(i_lui, 4'b0000, ST_LUI,    lui_c, 0, ir)); ir++;
        vecs.push_back(mkv(i_auipc, 4'b0001, ST_FETCH,  f_go,  0, ir));
        vecs.push_back(mkv(i_auipc, 4'b0000, ST_DECODE, d_u,   0, ir));
        vecs.push_back(mkv(i_auipc, 4'b0000, ST_AUIPC,  aluwb, 0, ir)); ir++;
        vecs.push_back(mkv(i_jalr, 4'b0001, ST_FETCH,  f_go,   0, ir));
        vecs.push_back(mkv(i_jalr, 4'b0000, ST_DECODE, d_i,    0, ir));
        vecs.push_back(mkv(i_jalr, 4'b0000, ST_JALR_A, jalra,  0, ir));
        vecs.push_back(mkv(i_jalr, 4'b0001, ST_JALR,   jalr_c, 0, ir)); ir++;
        // jal x1,16 then an all-ones word that must trap
        vecs.push_back(mkv(i_jal, 4'b0001, ST_FETCH,  f_go,  0, ir));
        vecs.push_back(mkv(i_jal, 4'b0000, ST_DECODE, d_j,   0, ir));
        vecs.push_back(mkv(i_jal, 4'b0000, ST_JAL,    jal_c, 0, ir)); ir++;
        vecs.push_back(mkv(i_bad, 4'b0001, ST_FETCH,  f_go,  0, ir));
        vecs.push_back(mkv(i_bad, 4'b0001, ST_DECODE, d_i,   0, ir));
        vecs.push_back(mkv(i_bad, 4'b0001, ST_TRAP,   none,  1, ir));
        vecs.push_back(mkv(i_addi, 4'b1111, ST_TRAP,  none,  1, ir));
        vecs.push_back(mkv(i_lw,   4'b0001, ST_TRAP,  none,  1, ir));

        // Reset state
        bus.inst = '0;
        {bus.zero, bus.lt, bus.ltu, bus.mem_ready} = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check("reset state",   64'(bus.state),     64'(ST_FETCH));
        check("reset ctl",     64'(act_ctl),       64'(f_wait));
        check("reset illegal", 64'(bus.illegal),   64'd0);
        check("reset cycles",  64'(bus.cycle_cnt), 64'd0);
        check("reset instret", 64'(bus.instret),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

        // Async reset clears the sticky trap without waiting for a clock edge
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("trap reset state",   64'(bus.state),     64'(ST_FETCH));
        check("trap reset illegal", 64'(bus.illegal),   64'd0);
        check("trap reset instret", 64'(bus.instret),   64'd0);
        check("trap reset cycles",  64'(bus.cycle_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        apply(mkv(i_addi, 4'b0001, ST_FETCH,  f_go,   0, 0), "seq addi fetch");
        apply(mkv(i_addi, 4'b0001, ST_DECODE, d_i,    0, 0), "seq addi decode");
        apply(mkv(i_addi, 4'b0001, ST_EXE_I,  exe_i,  0, 0), "seq addi exe");
        apply(mkv(i_addi, 4'b0001, ST_ALUWB,  aluwb,  0, 0), "seq addi wb");
        apply(mkv(i_lw,   4'b0001, ST_FETCH,  f_go,   0, 1), "seq lw fetch");
        apply(mkv(i_lw,   4'b0001, ST_DECODE, d_i,    0, 1), "seq lw decode");
        apply(mkv(i_lw,   4'b0000, ST_MEMADR, madr_i, 0, 1), "seq lw memadr");
        apply(mkv(i_lw,   4'b0000, ST_MEMRD,  mrd,    0, 1), "seq lw wait");

        // Still waiting in MEMRD; reset mid-cycle must abort before the next edge
        check("pre-abort state", 64'(bus.state), 64'(ST_MEMRD));
        #2 rst_n = 1'b0;
        #1;
        check("abort state",   64'(bus.state),     64'(ST_FETCH));
        check("abort ctl",     64'(act_ctl),       64'(f_wait));
        check("abort cycles",  64'(bus.cycle_cnt), 64'd0);
        check("abort instret", 64'(bus.instret),   64'd0);
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("held reset state",  64'(bus.state),     64'(ST_FETCH));
        check("held reset cycles", 64'(bus.cycle_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I teaching core; sequences the shared datapath (single ALU, single memory port, register file, PC/IR registers, immediate generator) one step per state.
- Decodes the latched instruction and drives the immediate-generator select, ALU operand muxes, write-enables and the memory request handshake.
- Also keeps cycle and retired-instruction counters for the lab's debug display.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH)
- CNT_W, 32, width of cycle/instret counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  current IR contents (opcode [6:0], funct3 [14:12], funct7 bit 30)
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  store when mem_req=1
- iord  out  1  memory address: 0=PC, 1=ALUOut
- ir_we  out  1  latch fetched word into IR
- pc_we  out  1  PC write
- pc_sel  out  2  PC source: 00 ALU result, 01 ALUOut, 10 ALUOut&~1
- old_pc_we  out  1  save PC of the fetched instruction
- ImmSel  out  3  000 U, 001 I, 010 S, 011 B, 100 J
- alu_a  out  2  00 PC, 01 rs1, 10 old PC
- alu_b  out  2  00 rs2, 01 imm, 10 const 4
- alu_mode  out  2  00 add, 01 R-type funct, 10 I-type funct, 11 sub/compare
- reg_we  out  1  register-file write
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC, 11 imm
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state (debug)
- cycle_cnt  out  CNT_W  cycles since reset
- instret  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0): state=FETCH, all counters 0, illegal=0. All strobe outputs are combinational from state and are therefore 0 except FETCH's mem_req=1.
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), LDWB(4), MEMWR(5), EXE_R(6), EXE_I(7), ALUWB(8), BRANCH(9), JAL(10), JALR_A(11), JALR(12), LUI(13), AUIPC(14), TRAP(15).
- FETCH: mem_req=1, iord=0. Stays while mem_ready=0. When mem_ready=1: ir_we=1, old_pc_we=1, pc_we=1, pc_sel=00, alu_a=00, alu_b=10, alu_mode=00 (PC+4). Next state: DECODE.
- DECODE: ImmSel from opcode (B for 1100011, J for 1101111, U for 0010111, I otherwise); alu_a=10, alu_b=01, add; the result lands in ALUOut as the target.
- DECODE transitions by opcode:
  - 0000011 and 0100011 -> MEMADR
  - 0110011 -> EXE_R
  - 0010011 -> EXE_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_A
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode -> TRAP
- MEMADR: alu_a=01, alu_b=01, ImmSel I (loads) or S (stores), add. Next: MEMRD for loads, MEMWR for stores.
- MEMRD: mem_req=1, iord=1; waits for mem_ready, then goes to LDWB.
- LDWB: reg_we=1, wb_sel=01.
- MEMWR: mem_req=1, mem_we=1, iord=1; waits for mem_ready, then goes to FETCH.
- EXE_R: alu_a=01, alu_b=00, mode 01. EXE_I: alu_a=01, alu_b=01, ImmSel I, mode 10. Both go to ALUWB.
- ALUWB: reg_we=1, wb_sel=00.
- BRANCH: alu_a=01, alu_b=00, mode 11. Taken is decided by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. pc_we=taken with pc_sel=01. An unsupported funct3 (010/011) is never taken.
- JAL: reg_we=1, wb_sel=10 (PC already +4), pc_we=1, pc_sel=01.
- JALR_A: alu_a=01, alu_b=01, ImmSel I, add.
- JALR: reg_we=1, wb_sel=10, pc_we=1, pc_sel=10.
- LUI: ImmSel U, reg_we=1, wb_sel=11.
- AUIPC: reg_we=1, wb_sel=00.
- All of LDWB, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC and MEMWR-on-ready retire the instruction: instret+1, then go to FETCH.
- TRAP: illegal=1 (sticky). All strobes are 0; the block stays in TRAP until reset.
- cycle_cnt increments every cycle out of reset. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-instruction aborts immediately with no partial strobes. mem_ready outside MEMRD/MEMWR/FETCH is ignored.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready=1 -> states FETCH, DECODE, EXE_I, ALUWB, FETCH; reg_we in cycle 4, ImmSel=001, instret=1.
- lw x2,4(x1) (0x0040A103) with mem_ready held low 3 cycles in MEMRD -> mem_req and iord held 4 cycles; LDWB wb_sel=01; total 8 cycles.
- sw x2,8(x1) (0x0020A423) -> MEMADR ImmSel=010, then MEMWR mem_we=1; reg_we never asserted.
- beq x0,x0,8 (0x00000463) with zero=1 -> BRANCH pc_we=1, pc_sel=01. Same instruction with zero=0 -> pc_we=0; instret increments in both cases.
- jal x1,16 (0x010000EF), then inst=0xFFFFFFFF -> JAL reg_we=1, wb_sel=10, pc_we=1; next decode goes to TRAP, illegal=1 and persists until rst_n=0 clears it.
- rst_n pulsed low during MEMRD wait -> state=0, counters=0 asynchronously, before the next clk edge.
